mdu_ctrl: RTL
=============

Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide sequencer for the EX stage. Sits beside the single-cycle ALU.
- Accepts one mult/div operation at a time and holds HI/LO.
- Counts out a fixed latency per operation and drives `busy` to the pipeline stall logic.
- Services mthi/mtlo writes and mfhi/mflo reads.

Parameters:
- MULT_CYC, 5, cycles `busy` stays high for mult/multu (legal range 1..15)
- DIV_CYC, 10, cycles `busy` stays high for div/divu (legal range 1..15)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state
- start  in  1  request qualifier; op and operands sampled at rising edge when 1
- MDUOp  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9-15 none
- A  in  32  operand rs (dividend / multiplicand / mthi-mtlo data)
- B  in  32  operand rt (divisor / multiplier)
- busy  out  1  operation in flight
- HI  out  32  HI register
- LO  out  32  LO register
- out  out  32  combinational: HI if MDUOp=7, LO if MDUOp=8, else 0 (independent of start/busy)

Behaviour:
- States: IDLE, MUL_RUN, DIV_RUN.
- Internal registers:
  - 4-bit down-counter `cnt`
  - latched result registers `res_hi`, `res_lo`
  - latched op
- Reset (async, reset=0):
  - state=IDLE, cnt=0, busy=0, HI=0, LO=0, res_hi=0, res_lo=0.
  - Takes effect immediately, including mid-operation; the in-flight result is discarded.
- IDLE, start=1:
  - Op 1/2: compute the 64-bit product into res_hi:res_lo, cnt=MULT_CYC-1, go to MUL_RUN.
  - Op 3/4: compute the quotient into res_lo and the remainder into res_hi, cnt=DIV_CYC-1, go to DIV_RUN.
  - Op 5: HI<=A at this edge, stay in IDLE.
  - Op 6: LO<=A at this edge, stay in IDLE.
  - Op 7/8/none: no state change.
- MUL_RUN/DIV_RUN:
  - `busy`=1 in every cycle while in these states.
  - Each edge: if cnt!=0 then cnt<=cnt-1.
  - If cnt==0: HI<=res_hi, LO<=res_lo, go to IDLE.
- Timing:
  - Start accepted at edge E0 → busy=1 for exactly N cycles (N=MULT_CYC or DIV_CYC).
  - HI/LO update and busy falls together at edge E0+N.
  - A new start is accepted at edge E0+N.
- start=1 while busy (any op, including mthi/mtlo):
  - Ignored; no state, counter or HI/LO change.
  - The pipeline must stall on busy | (start & MDUOp in 1..6).
- Arithmetic rules:
  - mult: signed 32x32→64.
  - multu: unsigned 32x32→64.
  - div: signed quotient truncates toward zero; the remainder takes the dividend's sign.
  - div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
  - divu: unsigned.
- Divide by zero (B=0, op 3/4):
  - Still runs DIV_CYC cycles with busy=1.
  - HI and LO are left unchanged at completion.
- Operands are sampled only at the accept edge; changes to A/B during busy have no effect.

Optional Feature:
- Macro: MDU_CANCEL_EN.
- Defined:
  - Adds input port `cancel` (1 bit), used for exception/flush.
  - cancel=1 at an edge while in MUL_RUN/DIV_RUN → go to IDLE, busy=0 after that edge, HI/LO unchanged.
  - cancel=1 in IDLE with start=1 → start is suppressed; mthi/mtlo are also suppressed.
  - cancel has priority over completion in the same cycle.
- Undefined:
  - No `cancel` port.
  - Operations always complete.

Test Plan:
- Signed mult: reset release, start with MDUOp=1, A=0xFFFFFFFD (-3), B=7.
  - Required: busy=1 for exactly 5 cycles.
  - Required: HI=0xFFFFFFFF, LO=0xFFFFFFEB on the edge where busy falls.
  - Required: out=0 with MDUOp=0.
- Unsigned mult: MDUOp=2, A=0xFFFFFFFF, B=2 → after 5 cycles HI=0x00000001, LO=0xFFFFFFFE; MDUOp=7 → out=0x00000001.
- Signed div: MDUOp=3, A=0xFFFFFFF9 (-7), B=2 → busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Divide by zero:
  - Precondition: HI=0x12345678 via mthi (MDUOp=5, A=0x12345678) and LO=0x9ABCDEF0 via mtlo.
  - Stimulus: divu with A=7, B=0.
  - Required: busy for 10 cycles; HI/LO unchanged afterwards.
- Busy collision and reset:
  - Start mult A=3, B=4; assert start mult A=5, B=6 plus an mthi during busy.
  - Required: the extra requests are ignored and the final LO=12, HI=0.
  - Repeat, dropping reset low for 1 cycle at busy cycle 2.
  - Required: busy=0, HI=LO=0 immediately.
- With MDU_CANCEL_EN defined:
  - Start div A=100, B=3; pulse cancel in busy cycle 4.
  - Required: busy=0 after that edge, HI/LO keep their prior values.
  - Required: a following mult A=2, B=3 yields LO=6 after 5 cycles.

Source files
------------

// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: request/result bundle between EX-stage control and the MDU.
// With MDU_CANCEL_EN defined it also carries the flush/exception cancel.
interface mdu_ctrl_if;
    logic        start;
    logic [3:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] out;
`ifdef MDU_CANCEL_EN
    logic        cancel;
    modport slave  (input start, MDUOp, A, B, cancel, output busy, HI, LO, out);
    modport master (output start, MDUOp, A, B, cancel, input busy, HI, LO, out);
`else
    modport slave  (input start, MDUOp, A, B, output busy, HI, LO, out);
    modport master (output start, MDUOp, A, B, input busy, HI, LO, out);
`endif
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle mult/div sequencer holding HI/LO with fixed per-op latency.
// Optional MDU_CANCEL_EN adds a cancel input that aborts an in-flight op.
module mdu_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input logic        clk,
    input logic        reset,
    mdu_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN} state_t;
    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic [31:0] r_hi, r_lo, r_res_hi, r_res_lo;
    logic        w_cancel, w_go, w_sm, w_sd, w_an, w_bn, w_bz;
    logic [63:0] w_ax, w_bx, w_prod;
    logic [31:0] w_am, w_bm, w_q, w_r, w_quo, w_rem;
`ifdef MDU_CANCEL_EN
    assign w_cancel = bus.cancel;
`else
    assign w_cancel = 1'b0;
`endif
    assign w_go   = (r_state == IDLE) && bus.start && !w_cancel;
    assign w_sm   = bus.MDUOp == 4'd1;
    assign w_sd   = bus.MDUOp == 4'd3;
    // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then right for both
    assign w_ax   = {{32{w_sm & bus.A[31]}}, bus.A};
    assign w_bx   = {{32{w_sm & bus.B[31]}}, bus.B};
    assign w_prod = w_ax * w_bx;
    // Signed divide on magnitudes so 0x80000000 / -1 yields 0x80000000 without overflow
    assign w_an   = w_sd & bus.A[31];
    assign w_bn   = w_sd & bus.B[31];
    assign w_am   = w_an ? -bus.A : bus.A;
    assign w_bm   = w_bn ? -bus.B : bus.B;
    assign w_bz   = bus.B == 32'd0;
    assign w_q    = w_bz ? 32'd0 : w_am / w_bm;
    assign w_r    = w_bz ? 32'd0 : w_am % w_bm;
    assign w_quo  = (w_an ^ w_bn) ? -w_q : w_q;
    assign w_rem  = w_an ? -w_r : w_r;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_busy   <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_res_hi <= 32'd0;
            r_res_lo <= 32'd0;
        end else if (r_state == IDLE) begin
            if (w_go && (bus.MDUOp == 4'd1 || bus.MDUOp == 4'd2)) begin
                r_res_hi <= w_prod[63:32];
                r_res_lo <= w_prod[31:0];
                r_cnt    <= 4'(MULT_CYC - 1);
                r_busy   <= 1'b1;
                r_state  <= MUL_RUN;
            end else if (w_go && (bus.MDUOp == 4'd3 || bus.MDUOp == 4'd4)) begin
                // Divide by zero reloads the current HI/LO so completion leaves them unchanged
                r_res_hi <= w_bz ? r_hi : w_rem;
                r_res_lo <= w_bz ? r_lo : w_quo;
                r_cnt    <= 4'(DIV_CYC - 1);
                r_busy   <= 1'b1;
                r_state  <= DIV_RUN;
            end else if (w_go && bus.MDUOp == 4'd5) begin
                r_hi <= bus.A;
            end else if (w_go && bus.MDUOp == 4'd6) begin
                r_lo <= bus.A;
            end
        end else if (w_cancel) begin
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
        end else if (r_cnt == 4'd0) begin
            r_hi    <= r_res_hi;
            r_lo    <= r_res_lo;
            r_busy  <= 1'b0;
            r_state <= IDLE;
        end else begin
            r_cnt <= r_cnt - 4'd1;
        end
    end
    assign bus.busy = r_busy;
    assign bus.HI   = r_hi;
    assign bus.LO   = r_lo;
    assign bus.out  = bus.MDUOp == 4'd7 ? r_hi : bus.MDUOp == 4'd8 ? r_lo : 32'd0;
endmodule
